inst_fetch_queue: RTL and testbench

Byte-granular instruction fetch queue feeding the x86 decode stage. Accepts 64-bit fetch lines from the bus-side fetch logic, stores them in a circular byte buffer, and presents the oldest 15 bytes as a decode window. The decoder reports how many bytes it consumed each cycle, and the queue advances by exactly that amount. It is the producer side of the decoder's `buffer` / `byte_incr` interface.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_window_rotator.sv | 32 +++
 rtl/inst_fetch_queue.sv | 129 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: instruction window geometry and fetch-line size.
// Used by the fetch queue and the decoder so both agree on the window layout.
package fetch_pkg;

  localparam int MAX_INST_BYTES   = 15;
  localparam int FETCH_LINE_BYTES = 8;

  // Byte 0 of the window occupies bits [0:7] (oldest byte first).
  typedef logic [0:MAX_INST_BYTES*8-1] window_t;

  // Number of bytes a fetch line contributes after dropping the leading skip bytes.
  function automatic logic [3:0] line_payload(input logic [2:0] skip);
    return 4'(FETCH_LINE_BYTES) - {1'b0, skip};
  endfunction

endpackage

// File: rtl/fetch_window_rotator.sv
// Combinational rotate-and-mask: presents the oldest bytes of the circular store as
// the decode window, zeroing lanes beyond the number of valid bytes.
module fetch_window_rotator
  import fetch_pkg::*;
#(
  parameter int DEPTH_BYTES = 32,
  localparam int PTR_W = $clog2(DEPTH_BYTES),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [DEPTH_BYTES*8-1:0] storage,
  input  logic [PTR_W-1:0]         rd_ptr,
  input  logic [CNT_W-1:0]         count,
  output window_t                  window,
  output logic [3:0]               window_count
);

  logic [7:0] mem_bytes [DEPTH_BYTES];

  for (genvar k = 0; k < DEPTH_BYTES; k++) begin : g_unpack
    assign mem_bytes[k] = storage[k*8 +: 8];
  end

  assign window_count = (count > CNT_W'(MAX_INST_BYTES)) ? 4'(MAX_INST_BYTES) : count[3:0];

  // The read index wraps naturally because it is exactly PTR_W bits wide.
  for (genvar i = 0; i < MAX_INST_BYTES; i++) begin : g_lane
    logic [PTR_W-1:0] idx;
    assign idx = rd_ptr + PTR_W'(i);
    assign window[i*8 +: 8] = (4'(i) < window_count) ? mem_bytes[idx] : 8'h00;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Byte-granular instruction fetch queue feeding the decode window.
// Optional statistics counters are enabled with INST_FETCH_QUEUE_STATS_EN.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH_BYTES = 32,
  localparam int PTR_W = $clog2(DEPTH_BYTES),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill_valid,
  output logic        fill_ready,
  input  logic [63:0] fill_data,
  input  logic [2:0]  fill_skip,
  output window_t     window,
  output logic [3:0]  window_count,
  input  logic        consume_valid,
  input  logic [3:0]  consume_bytes,
  input  logic        flush,
  output logic        overrun_err
`ifdef INST_FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_bytes_consumed,
  output logic [31:0] stat_starve_cycles
`endif
);

  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic [DEPTH_BYTES*8-1:0] storage;

  logic       fill_fire;
  logic [3:0] fill_len;
  logic       consume_ok;
  logic       consume_bad;

  logic             wr_en   [DEPTH_BYTES];
  logic [7:0]       wr_byte [DEPTH_BYTES];

  assign fill_ready = (count <= CNT_W'(DEPTH_BYTES - FETCH_LINE_BYTES));
  assign fill_fire  = fill_valid && fill_ready;
  assign fill_len   = line_payload(fill_skip);

  // Legality uses the window as it stood before this cycle's fill lands.
  assign consume_ok  = consume_valid && (consume_bytes <= window_count);
  assign consume_bad = consume_valid && (consume_bytes >  window_count);

  always_comb begin
    count_next = count;
    if (fill_fire) count_next = count_next + CNT_W'(fill_len);
    if (consume_ok) count_next = count_next - CNT_W'(consume_bytes);
  end

  // Each storage byte checks whether it falls inside this cycle's write span.
  for (genvar k = 0; k < DEPTH_BYTES; k++) begin : g_wr
    logic [PTR_W-1:0] off;
    logic [2:0]       src;
    assign off        = PTR_W'(k) - wr_ptr;
    assign src        = off[2:0] + fill_skip;
    assign wr_en[k]   = fill_fire && !flush && (off < PTR_W'(fill_len));
    assign wr_byte[k] = fill_data[{src, 3'b000} +: 8];
  end

  // Byte storage holds no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH_BYTES; k++) begin
      if (wr_en[k]) storage[k*8 +: 8] <= wr_byte[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fill_fire) wr_ptr <= wr_ptr + PTR_W'(fill_len);
      if (consume_ok) rd_ptr <= rd_ptr + PTR_W'(consume_bytes);
      count <= count_next;
    end
  end

  // A flush wins over an illegal consume, so the error only latches without one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_err <= 1'b0;
    end else if (consume_bad && !flush) begin
      overrun_err <= 1'b1;
    end
  end

  fetch_window_rotator #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_rotator (
    .storage     (storage),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .window      (window),
    .window_count(window_count)
  );

`ifdef INST_FETCH_QUEUE_STATS_EN
  logic [32:0] consumed_sum;
  assign consumed_sum = {1'b0, stat_bytes_consumed} + 33'(consume_bytes);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bytes_consumed <= '0;
      stat_starve_cycles  <= '0;
    end else begin
      if (consume_ok && !flush) begin
        stat_bytes_consumed <= consumed_sum[32] ? 32'hFFFF_FFFF : consumed_sum[31:0];
      end
      if ((window_count < 4'(MAX_INST_BYTES)) && !flush && !fill_valid &&
          (stat_starve_cycles != 32'hFFFF_FFFF)) begin
        stat_starve_cycles <= stat_starve_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a byte-queue reference model.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        fill_valid;
  logic        fill_ready;
  logic [63:0] fill_data;
  logic [2:0]  fill_skip;
  window_t     window;
  logic [3:0]  window_count;
  logic        consume_valid;
  logic [3:0]  consume_bytes;
  logic        flush;
  logic        overrun_err;

  int vectors     = 0;
  int miscompares = 0;

  byte unsigned model_q[$];
  bit           model_err;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH_BYTES(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_data    (fill_data),
    .fill_skip    (fill_skip),
    .window       (window),
    .window_count (window_count),
    .consume_valid(consume_valid),
    .consume_bytes(consume_bytes),
    .flush        (flush),
    .overrun_err  (overrun_err)
  );

  function automatic int exp_wc();
    return (model_q.size() > MAX_INST_BYTES) ? MAX_INST_BYTES : model_q.size();
  endfunction

  function automatic bit exp_ready();
    return model_q.size() <= DEPTH - FETCH_LINE_BYTES;
  endfunction

  function automatic window_t exp_window();
    window_t w = '0;
    for (int i = 0; i < exp_wc(); i++) w[i*8 +: 8] = model_q[i];
    return w;
  endfunction

  // Drive one cycle of inputs, then advance the model by the queue rules.
  task automatic drive_cycle(input bit fv, input logic [63:0] fd, input logic [2:0] fs,
                             input bit cv, input logic [3:0] cb, input bit fl);
    int wc;
    bit rdy;
    fill_valid    = fv;
    fill_data     = fd;
    fill_skip     = fs;
    consume_valid = cv;
    consume_bytes = cb;
    flush         = fl;
    wc  = exp_wc();
    rdy = exp_ready();
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (cv) begin
        if (int'(cb) <= wc) repeat (int'(cb)) void'(model_q.pop_front());
        else model_err = 1'b1;
      end
      if (fv && rdy) begin
        for (int j = int'(fs); j < 8; j++) model_q.push_back(fd[j*8 +: 8]);
      end
    end
    #2;
    fill_valid    = 1'b0;
    consume_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fill_valid = 1'b0; fill_data = '0; fill_skip = '0;
    consume_valid = 1'b0; consume_bytes = '0; flush = 1'b0;
    model_q.delete();
    model_err = 1'b0;
    #12;
    vectors++; if (fill_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_fill_ready: got %b expected 1", fill_ready); end
    vectors++; if (window_count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_window_count: got %0d expected 0", window_count); end
    vectors++; if (window !== '0) begin miscompares++; $display("[TB] FAIL reset_window: got %h expected 0", window); end
    vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun_err); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic test_basic_fill();
    drive_cycle(1'b1, 64'h0706050403020100, 3'd0, 1'b0, 4'd0, 1'b0);
    vectors++; if (window_count !== 4'd8) begin miscompares++; $display("[TB] FAIL basic_count: got %0d expected 8", window_count); end
    vectors++; if (window[0:7] !== 8'h00) begin miscompares++; $display("[TB] FAIL basic_byte0: got %h expected 00", window[0:7]); end
    vectors++; if (window[56:63] !== 8'h07) begin miscompares++; $display("[TB] FAIL basic_byte7: got %h expected 07", window[56:63]); end
    vectors++; if (fill_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_ready: got %b expected 1", fill_ready); end
    vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL basic_window: got %h expected %h", window, exp_window()); end
  endtask

  task automatic test_full();
    drive_cycle(1'b0, '0, 3'd0, 1'b0, 4'd0, 1'b1);
    for (int n = 0; n < 4; n++) drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b0, 4'd0, 1'b0);
    vectors++; if (window_count !== 4'd15) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected 15", window_count); end
    vectors++; if (fill_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %b expected 0", fill_ready); end
    vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL full_window: got %h expected %h", window, exp_window()); end
    // Offered line while full must be dropped; the consume still applies.
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b1, 4'd8, 1'b0);
    vectors++; if (fill_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_drain_ready: got %b expected 1", fill_ready); end
    vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL full_drain_window: got %h expected %h", window, exp_window()); end
  endtask

  task automatic test_fill_and_consume();
    byte unsigned fourth;
    drive_cycle(1'b0, '0, 3'd0, 1'b0, 4'd0, 1'b1);
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b0, 4'd0, 1'b0);
    fourth = model_q[3];
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b1, 4'd3, 1'b0);
    vectors++; if (window_count !== 4'd13) begin miscompares++; $display("[TB] FAIL fc_count: got %0d expected 13", window_count); end
    vectors++; if (window[0:7] !== fourth) begin miscompares++; $display("[TB] FAIL fc_byte0: got %h expected %h", window[0:7], fourth); end
    vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL fc_window: got %h expected %h", window, exp_window()); end
  endtask

  task automatic test_skip();
    drive_cycle(1'b0, '0, 3'd0, 1'b0, 4'd0, 1'b1);
    drive_cycle(1'b1, 64'hAABBCCDDEEFF1122, 3'd5, 1'b0, 4'd0, 1'b0);
    vectors++; if (window_count !== 4'd3) begin miscompares++; $display("[TB] FAIL skip_count: got %0d expected 3", window_count); end
    vectors++; if (window[0:23] !== 24'hCCBBAA) begin miscompares++; $display("[TB] FAIL skip_bytes: got %h expected ccbbaa", window[0:23]); end
    vectors++; if (window[24:31] !== 8'h00) begin miscompares++; $display("[TB] FAIL skip_mask: got %h expected 00", window[24:31]); end
  endtask

  task automatic test_overrun();
    drive_cycle(1'b0, '0, 3'd0, 1'b0, 4'd0, 1'b1);
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd2, 1'b0, 4'd0, 1'b0);
    drive_cycle(1'b0, '0, 3'd0, 1'b1, 4'd9, 1'b0);
    vectors++; if (window_count !== 4'd6) begin miscompares++; $display("[TB] FAIL ovr_count: got %0d expected 6", window_count); end
    vectors++; if (overrun_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun_err); end
    vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL ovr_window: got %h expected %h", window, exp_window()); end
    drive_cycle(1'b0, '0, 3'd0, 1'b0, 4'd0, 1'b1);
    vectors++; if (overrun_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun_err); end
    vectors++; if (window_count !== 4'd0) begin miscompares++; $display("[TB] FAIL ovr_flush_count: got %0d expected 0", window_count); end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b0, '0, 3'd0, 1'b0, 4'd0, 1'b1);
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b0, 4'd0, 1'b0);
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b0, 4'd0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b1, 4'd8, 1'b0);
      vectors++; if (window_count !== 4'd15) begin miscompares++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected 15", n, window_count); end
      vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL wrap_window[%0d]: got %h expected %h", n, window, exp_window()); end
    end
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b1, 4'd4, 1'b1);
    vectors++; if (window_count !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_prio_count: got %0d expected 0", window_count); end
    vectors++; if (fill_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_prio_ready: got %b expected 1", fill_ready); end
  endtask

  task automatic test_random();
    bit fv, cv, fl;
    logic [2:0] fs;
    logic [3:0] cb;
    for (int n = 0; n < 400; n++) begin
      fv = ($urandom % 4) != 0;
      fs = ($urandom % 3 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      cv = ($urandom % 4) != 0;
      cb = ($urandom % 12 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, exp_wc()));
      fl = ($urandom % 40) == 0;
      drive_cycle(fv, {$urandom, $urandom}, fs, cv, cb, fl);
      vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL rand_window[%0d]: got %h expected %h", n, window, exp_window()); end
      vectors++; if (window_count !== 4'(exp_wc())) begin miscompares++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", n, window_count, exp_wc()); end
      vectors++; if (fill_ready !== exp_ready()) begin miscompares++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", n, fill_ready, exp_ready()); end
      vectors++; if (overrun_err !== model_err) begin miscompares++; $display("[TB] FAIL rand_overrun[%0d]: got %b expected %b", n, overrun_err, model_err); end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, {$urandom, $urandom}, 3'd0, 1'b0, 4'd0, 1'b0);
    drive_cycle(1'b0, '0, 3'd0, 1'b1, 4'd12, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    vectors++; if (window_count !== 4'd0) begin miscompares++; $display("[TB] FAIL async_count: got %0d expected 0", window_count); end
    vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("[TB] FAIL async_overrun: got %b expected 0", overrun_err); end
    vectors++; if (window !== '0) begin miscompares++; $display("[TB] FAIL async_window: got %h expected 0", window); end
    model_q.delete();
    model_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    drive_cycle(1'b1, 64'h1122334455667788, 3'd0, 1'b0, 4'd0, 1'b0);
    vectors++; if (window !== exp_window()) begin miscompares++; $display("[TB] FAIL async_refill: got %h expected %h", window, exp_window()); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_full();
    test_fill_and_consume();
    test_skip();
    test_overrun();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
